// File: rtl/ws_input_feeder.sv
// ws_input_feeder: buffers a weight tile, strobes it into the PE array, then streams diagonally skewed activations and drains with zeros.
module ws_input_feeder #(
  parameter int bit_width = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_W-1:0]                num_vec,
  input  logic                            wt_valid,
  output logic                            wt_ready,
  input  logic [COLS*bit_width-1:0]       wt_row,
  input  logic                            act_valid,
  output logic                            act_ready,
  input  logic [ROWS*bit_width-1:0]       act_vec,
  output logic                            pe_control,
  output logic [ROWS*COLS*bit_width-1:0]  pe_wt,
  output logic [ROWS*bit_width-1:0]       pe_data,
  output logic                            busy,
  output logic                            done
);
  localparam int IW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(ROWS + COLS);
  typedef enum logic [2:0] {IDLE, WLOAD, WAPPLY, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [CNT_W-1:0] remaining;
  logic [DW-1:0] dcnt;
  logic wt_acc, act_acc, last_row, drain_end;
  assign wt_ready   = state == WLOAD;
  assign act_ready  = state == STREAM && remaining != '0;
  assign wt_acc     = wt_valid && wt_ready;
  assign act_acc    = act_valid && act_ready;
  assign last_row   = idx == IW'(ROWS - 1);
  assign drain_end  = dcnt == DW'(ROWS + COLS - 2);
  assign pe_control = state == WAPPLY;
  assign busy       = state != IDLE;
  assign done       = state == DRAIN && drain_end;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? WLOAD : IDLE;
      WLOAD:   state_n = (wt_acc && last_row) ? WAPPLY : WLOAD;
      WAPPLY:  state_n = remaining == '0 ? DRAIN : STREAM;
      STREAM:  state_n = (act_acc && remaining == CNT_W'(1)) ? DRAIN : STREAM;
      DRAIN:   state_n = drain_end ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      dcnt      <= '0;
      pe_wt     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        remaining <= num_vec;
        idx       <= '0;
      end
      if (wt_acc) idx <= idx + IW'(1);
      if (act_acc) remaining <= remaining - CNT_W'(1);
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      for (int r = 0; r < ROWS; r++)
        if (wt_acc && idx == IW'(r)) pe_wt[r*COLS*bit_width +: COLS*bit_width] <= wt_row;
    end
  end
  // Lane r has r skew stages ahead of its output stage; non-accept cycles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [bit_width-1:0] sr [r+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sr[k] <= '0;
      end else begin
        sr[0] <= act_acc ? act_vec[r*bit_width +: bit_width] : '0;
        for (int k = 1; k <= r; k++) sr[k] <= sr[k-1];
      end
    end
    assign pe_data[r*bit_width +: bit_width] = sr[r];
  end
endmodule

// File: tb/tb_ws_input_feeder.sv
// tb_ws_input_feeder: randomized tiles checked against a history-based model of accepted weights and activation vectors.
module tb_ws_input_feeder;
  logic clk = 0, rst = 1, start = 0, wt_valid = 0, act_valid = 0;
  logic [15:0] num_vec = '0;
  logic [31:0] wt_row = '0, act_vec = '0;
  logic wt_ready, act_ready, pe_control, busy, done;
  logic [127:0] pe_wt;
  logic [31:0] pe_data;
  int tests = 0, fails = 0, cyc = 0, widx = 0, nacc = 0;
  logic [31:0] mw [4];
  bit hv [8192];
  logic [31:0] hd [8192];
  bit ab;
  logic [7:0] pe23;

  ws_input_feeder dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_vec(act_vec),
    .pe_control(pe_control), .pe_wt(pe_wt), .pe_data(pe_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Row r of the skewed output shows element r of the vector accepted r+1 cycles earlier.
  function automatic logic [31:0] exp_data();
    logic [31:0] e = '0;
    for (int r = 0; r < 4; r++) begin
      int t = cyc - 1 - r;
      if (t >= 0 && hv[t]) e[r*8 +: 8] = hd[t][r*8 +: 8];
    end
    return e;
  endfunction

  // ph: 0 idle, 1 weight load, 2 weight apply, 3 stream, 4 drain
  task automatic step(input int ph, input bit last);
    @(negedge clk);
    chk("wt_ready", 128'(wt_ready), 128'(ph == 1));
    chk("act_ready", 128'(act_ready), 128'(ph == 3));
    chk("pe_control", 128'(pe_control), 128'(ph == 2));
    chk("busy", 128'(busy), 128'(ph != 0));
    chk("done", 128'(done), 128'(ph == 4 && last));
    chk("pe_wt", pe_wt, {mw[3], mw[2], mw[1], mw[0]});
    chk("pe_data", 128'(pe_data), 128'(exp_data()));
    if (ph == 1 && wt_valid) begin
      mw[widx] = wt_row;
      widx++;
    end
    if (ph == 3 && act_valid) begin
      hv[cyc] = 1;
      hd[cyc] = act_vec;
      nacc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; wt_valid = 0; act_valid = 0;
    @(negedge clk);
    chk("rst_pe_wt", pe_wt, 128'h0);
    chk("rst_pe_data", 128'(pe_data), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_ctrl", 128'(pe_control), 128'h0);
    chk("rst_ready", 128'({wt_ready, act_ready}), 128'h0);
    for (int i = 0; i < 4; i++) mw[i] = '0;
    for (int i = 0; i < 8192; i++) hv[i] = 0;
    @(posedge clk);
    #1;
    rst = 0;
    cyc++;
  endtask

  // mode 0 random, 1 directed weights, 2 toggled valid, 3 directed single vector
  task automatic tile(input int n, input int mode, input int rst_after, output bit aborted);
    aborted = 0;
    start = 1; num_vec = 16'(n);
    step(0, 0);
    start = 0; num_vec = 16'($urandom);
    widx = 0;
    while (widx < 4) begin
      wt_valid = (mode == 1 || mode == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) wt_row[c*8 +: 8] = mode == 1 ? 8'(16 * widx + c) : 8'($urandom);
      step(1, 0);
    end
    wt_valid = 0;
    step(2, 0);
    nacc = 0;
    for (int k = 0; nacc < n; k++) begin
      if (nacc == rst_after) begin
        aborted = 1;
        return;
      end
      act_valid = mode == 3 ? 1'b1 : mode == 2 ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      act_vec = mode == 3 ? 32'h04030201 : $urandom;
      start = 1'($urandom_range(0, 1));
      wt_valid = 1;
      wt_row = $urandom;
      step(3, 0);
    end
    wt_valid = 0;
    act_valid = 1;
    for (int i = 0; i < 7; i++) begin
      start = i < 6 ? 1'($urandom_range(0, 1)) : 1'b0;
      step(4, i == 6);
    end
    act_valid = 0;
    start = 0;
  endtask

  initial begin
    do_reset();
    tile(0, 1, -1, ab);
    pe23 = pe_wt[(2*4+3)*8 +: 8];
    chk("pe_2_3", 128'(pe23), 128'h23);
    tile(1, 3, -1, ab);
    tile(3, 2, -1, ab);
    for (int i = 0; i < 6; i++) tile($urandom_range(0, 12), 0, -1, ab);
    tile(8, 0, 4, ab);
    chk("aborted", 128'(ab), 128'h1);
    do_reset();
    tile(5, 0, -1, ab);
    tile(2, 2, -1, ab);
    step(0, 0);
    step(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
